// File: rtl/bus_valve_ctrl_pkg.sv
// Shared types for the OMNIBUS valve controller.
// Bus holds the protocol enums used by every bus-side block; bus_valve_ctrl_pkg
// holds the controller's own state type and timer sizing helper.

package Bus;
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} Cmd;
    typedef enum logic [1:0] {NULL = 2'd0, DVA = 2'd1, ERR = 2'd3} Resp;
endpackage

package bus_valve_ctrl_pkg;
    typedef enum logic [1:0] {OPEN = 2'd0, DRAIN = 2'd1, CLOSED = 2'd2} Valve_state;

    localparam int DEFAULT_TIMEOUT = 1024;

    // Timer must hold TIMEOUT-1; never narrower than one bit.
    function automatic int timer_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int DEFAULT_TMR_W = timer_width(DEFAULT_TIMEOUT);
endpackage

// File: rtl/bus_valve_ctrl_if.sv
// OMNIBUS point-to-point link: master drives commands, slave returns responses.

interface Bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    Bus::Cmd               MCmd;
    logic [ADDR_W-1:0]     MAddr;
    logic [DATA_W-1:0]     MData;
    logic [DATA_W/8-1:0]   MByteEn;
    logic                  MReset_n;
    logic                  MRespAccept;
    logic                  SCmdAccept;
    Bus::Resp              SResp;
    logic [DATA_W-1:0]     SData;

    modport master (
        output MCmd, MAddr, MData, MByteEn, MReset_n, MRespAccept,
        input  SCmdAccept, SResp, SData
    );

    modport slave (
        input  MCmd, MAddr, MData, MByteEn, MReset_n, MRespAccept,
        output SCmdAccept, SResp, SData
    );
endinterface

// File: rtl/bus_valve_ctrl_cnt.sv
// Saturating up/down counter of outstanding bus transactions.
// clr wins over inc/dec; overflow is sticky until reset.

module bus_outstanding_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             zero,
    output logic             overflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    // Next count: simultaneous inc/dec cancel, saturate high, floor at zero.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Counter and sticky overflow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign zero     = (count_q == '0);
    assign overflow = ovf_q;
endmodule

// File: rtl/bus_valve_ctrl.sv
// OMNIBUS valve sequencer: stops new commands, waits for outstanding
// responses (or a timeout), then closes the valve.
//
// state  | meaning
// OPEN   | full pass-through, valve open
// DRAIN  | new commands blocked, waiting for outstanding responses
// CLOSED | valve_close asserted, path isolated by the valve

module bus_valve_ctrl
    import bus_valve_ctrl_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter bit WRITE_RESP = 1'b0,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic  clk,
    input  logic  reset,
    Bus_if.slave  in,
    Bus_if.master out,
    input  logic  close_req,
    output logic  valve_close,
    output logic  closed,
    output logic  draining,
    output logic  timeout,
    output logic  overflow
);
    localparam int TMR_W = timer_width(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    Valve_state       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             timeout_q, timeout_d;
    logic             force_close;

    logic             cmd_acc, cnt_cmd, rsp_acc, cnt_clr, cnt_zero;
    logic [CNT_W-1:0] count;

    // Pass-through; only the command and its accept are gated while draining.
    assign out.MCmd        = (state_q == DRAIN) ? Bus::IDLE : in.MCmd;
    assign in.SCmdAccept   = (state_q == DRAIN) ? 1'b0 : out.SCmdAccept;
    assign out.MAddr       = in.MAddr;
    assign out.MData       = in.MData;
    assign out.MByteEn     = in.MByteEn;
    assign out.MReset_n    = in.MReset_n;
    assign out.MRespAccept = in.MRespAccept;
    assign in.SResp        = out.SResp;
    assign in.SData        = out.SData;

    // Handshake events seen on the valve side of the gate.
    assign cmd_acc = (out.MCmd != Bus::IDLE) && out.SCmdAccept;
    assign cnt_cmd = cmd_acc && ((out.MCmd == Bus::READ) ||
                                 (WRITE_RESP && (out.MCmd == Bus::WRITE)));
    assign rsp_acc = (out.SResp != Bus::NULL) && in.MRespAccept;

    // Counter is pinned at zero while closed and flushed on a forced close.
    assign cnt_clr = force_close || (state_q == CLOSED);

    bus_outstanding_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (cnt_cmd),
        .dec      (rsp_acc),
        .clr      (cnt_clr),
        .count    (count),
        .zero     (cnt_zero),
        .overflow (overflow)
    );

    // Next-state logic; in DRAIN a release beats completion, completion beats timeout.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        timeout_d   = timeout_q;
        force_close = 1'b0;
        case (state_q)
            OPEN: begin
                if (close_req) begin
                    state_d   = DRAIN;
                    timer_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            DRAIN: begin
                timer_d = timer_q + TMR_W'(1);
                if (!close_req) begin
                    state_d = OPEN;
                end else if (cnt_zero || ((count == CNT_W'(1)) && rsp_acc)) begin
                    state_d = CLOSED;
                end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
                    state_d     = CLOSED;
                    timeout_d   = 1'b1;
                    force_close = 1'b1;
                end
            end
            CLOSED: begin
                if (!close_req) begin
                    state_d = OPEN;
                end
            end
            default: state_d = OPEN;
        endcase
    end

    // State, drain timer and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= OPEN;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign valve_close = (state_q == CLOSED);
    assign closed      = (state_q == CLOSED);
    assign draining    = (state_q == DRAIN);
    assign timeout     = timeout_q;
endmodule

// File: tb/tb_bus_valve_ctrl.sv
// Bench for bus_valve_ctrl: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the valve sequencing.

module tb_bus_valve_ctrl;
    localparam int CNT_W = 2;
    localparam int CMAX  = 3;
    localparam int TMO   = 16;

    localparam int M_OPEN   = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_CLOSED = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic close_req;
    logic valve_close, closed, draining, timeout, overflow;

    Bus_if bus_in ();
    Bus_if bus_out ();

    bus_valve_ctrl #(
        .CNT_W      (CNT_W),
        .WRITE_RESP (1'b0),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (bus_in),
        .out         (bus_out),
        .close_req   (close_req),
        .valve_close (valve_close),
        .closed      (closed),
        .draining    (draining),
        .timeout     (timeout),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: mode, outstanding transactions, cycles spent draining, sticky flags.
    int m_mode = M_OPEN;
    int m_cnt  = 0;
    int m_dc   = 0;
    bit m_tmo  = 1'b0;
    bit m_ovf  = 1'b0;

    Bus::Cmd     cur_cmd;
    bit          cur_acc;
    Bus::Resp    cur_rsp;
    bit          cur_racc;
    bit          cur_creq;
    logic [31:0] cur_addr;
    logic [31:0] cur_sdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_OPEN;
        m_cnt  = 0;
        m_dc   = 0;
        m_tmo  = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_regs();
        chk("draining",    draining,    (m_mode == M_DRAIN));
        chk("closed",      closed,      (m_mode == M_CLOSED));
        chk("valve_close", valve_close, (m_mode == M_CLOSED));
        chk("timeout",     timeout,     m_tmo);
        chk("overflow",    overflow,    m_ovf);
        chk("count",       dut.u_cnt.count_q, m_cnt);
    endtask

    // Apply one cycle of stimulus and check the combinational pass-through.
    task automatic drive(input Bus::Cmd cmd, input bit acc, input Bus::Resp rsp,
                         input bit racc, input bit creq);
        cur_cmd   = cmd;
        cur_acc   = acc;
        cur_rsp   = rsp;
        cur_racc  = racc;
        cur_creq  = creq;
        cur_addr  = $urandom;
        cur_sdata = $urandom;
        bus_in.MCmd         = cmd;
        bus_in.MAddr        = cur_addr;
        bus_in.MData        = ~cur_addr;
        bus_in.MByteEn      = 4'hF;
        bus_in.MReset_n     = 1'b1;
        bus_in.MRespAccept  = racc;
        bus_out.SCmdAccept  = acc;
        bus_out.SResp       = rsp;
        bus_out.SData       = cur_sdata;
        close_req           = creq;
        #1;
        chk("out_mcmd",  bus_out.MCmd, (m_mode == M_DRAIN) ? Bus::IDLE : cmd);
        chk("in_cmdacc", bus_in.SCmdAccept, (m_mode == M_DRAIN) ? 1'b0 : acc);
        chk("out_maddr", bus_out.MAddr, cur_addr);
        chk("in_sresp",  bus_in.SResp, rsp);
        chk("in_sdata",  bus_in.SData, cur_sdata);
    endtask

    // Advance the model across one clock edge and compare registered outputs.
    task automatic tick();
        bit accepted, counted, rsp;
        int n_mode, n_cnt, n_dc;
        bit n_tmo, n_ovf;
        accepted = (m_mode != M_DRAIN) && (cur_cmd != Bus::IDLE) && cur_acc;
        counted  = accepted && (cur_cmd == Bus::READ);
        rsp      = (cur_rsp != Bus::NULL) && cur_racc;
        n_mode = m_mode;
        n_dc   = m_dc;
        n_tmo  = m_tmo;
        n_ovf  = m_ovf;
        if (m_mode == M_CLOSED) begin
            n_cnt = 0;
        end else begin
            n_cnt = m_cnt + int'(counted) - int'(rsp);
            if (n_cnt > CMAX) begin
                n_cnt = CMAX;
                n_ovf = 1'b1;
            end
            if (n_cnt < 0) n_cnt = 0;
        end
        case (m_mode)
            M_OPEN: if (cur_creq) begin
                n_mode = M_DRAIN;
                n_dc   = 0;
                n_tmo  = 1'b0;
            end
            M_DRAIN: begin
                n_dc = m_dc + 1;
                if (!cur_creq) n_mode = M_OPEN;
                else if (n_cnt == 0) n_mode = M_CLOSED;
                else if (n_dc == TMO) begin
                    n_mode = M_CLOSED;
                    n_tmo  = 1'b1;
                    n_cnt  = 0;
                end
            end
            default: if (!cur_creq) n_mode = M_OPEN;
        endcase
        @(posedge clk);
        #1;
        m_mode = n_mode;
        m_cnt  = n_cnt;
        m_dc   = n_dc;
        m_tmo  = n_tmo;
        m_ovf  = n_ovf;
        check_regs();
    endtask

    task automatic cyc(input Bus::Cmd cmd, input bit acc, input Bus::Resp rsp,
                       input bit racc, input bit creq);
        drive(cmd, acc, rsp, racc, creq);
        tick();
    endtask

    initial begin
        Bus::Cmd  rc;
        Bus::Resp rr;
        bit       creq;
        int       rpct;

        bus_in.MCmd        = Bus::IDLE;
        bus_in.MAddr       = '0;
        bus_in.MData       = '0;
        bus_in.MByteEn     = '0;
        bus_in.MReset_n    = 1'b1;
        bus_in.MRespAccept = 1'b0;
        bus_out.SCmdAccept = 1'b0;
        bus_out.SResp      = Bus::NULL;
        bus_out.SData      = '0;
        close_req          = 1'b0;
        cur_cmd = Bus::IDLE; cur_acc = 1'b0; cur_rsp = Bus::NULL;
        cur_racc = 1'b0; cur_creq = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_regs();

        // Idle close: draining after 1 edge, closed after 2, release in 1.
        cyc(Bus::IDLE, 0, Bus::NULL, 0, 1);
        chk("idle_drain", draining, 1'b1);
        chk("idle_vc_early", valve_close, 1'b0);
        cyc(Bus::IDLE, 0, Bus::NULL, 0, 1);
        chk("idle_vc", valve_close, 1'b1);
        cyc(Bus::IDLE, 0, Bus::NULL, 0, 1);
        cyc(Bus::IDLE, 0, Bus::NULL, 0, 0);
        chk("idle_release", valve_close, 1'b0);

        // Drain with reads; the read presented with close_req still counts.
        cyc(Bus::READ, 1, Bus::NULL, 0, 0);
        cyc(Bus::READ, 1, Bus::NULL, 0, 0);
        cyc(Bus::READ, 1, Bus::NULL, 0, 1);
        chk("drain_cnt3", dut.u_cnt.count_q, 2'd3);
        cyc(Bus::READ, 1, Bus::NULL, 1, 1);
        cyc(Bus::READ, 1, Bus::DVA,  1, 1);
        cyc(Bus::READ, 1, Bus::DVA,  0, 1);
        chk("drain_noracc", dut.u_cnt.count_q, 2'd2);
        cyc(Bus::READ, 1, Bus::DVA,  1, 1);
        chk("drain_not_yet", valve_close, 1'b0);
        cyc(Bus::READ, 1, Bus::DVA,  1, 1);
        chk("drain_closed", valve_close, 1'b1);
        cyc(Bus::IDLE, 0, Bus::NULL, 0, 0);

        // Simultaneous inc/dec and posted writes.
        cyc(Bus::READ,  1, Bus::NULL, 0, 0);
        cyc(Bus::READ,  1, Bus::DVA,  1, 0);
        chk("simul_cnt", dut.u_cnt.count_q, 2'd1);
        cyc(Bus::WRITE, 1, Bus::NULL, 0, 0);
        chk("posted_wr", dut.u_cnt.count_q, 2'd1);
        cyc(Bus::READ,  0, Bus::NULL, 0, 0);
        cyc(Bus::IDLE,  0, Bus::ERR,  1, 0);
        chk("err_dec", dut.u_cnt.count_q, 2'd0);

        // Timeout: one read never answered.
        cyc(Bus::READ, 1, Bus::NULL, 0, 0);
        cyc(Bus::IDLE, 0, Bus::NULL, 0, 1);
        for (int k = 0; k < TMO - 1; k++) cyc(Bus::IDLE, 0, Bus::NULL, 0, 1);
        chk("tmo_last_drain", draining, 1'b1);
        cyc(Bus::IDLE, 0, Bus::NULL, 0, 1);
        chk("tmo_closed", closed, 1'b1);
        chk("tmo_flag", timeout, 1'b1);
        chk("tmo_cnt", dut.u_cnt.count_q, 2'd0);
        cyc(Bus::IDLE, 0, Bus::DVA, 1, 1);
        chk("late_dva", dut.u_cnt.count_q, 2'd0);
        cyc(Bus::IDLE, 0, Bus::NULL, 0, 0);
        chk("tmo_sticky", timeout, 1'b1);

        // Abort during DRAIN with two outstanding.
        cyc(Bus::READ, 1, Bus::NULL, 0, 0);
        cyc(Bus::READ, 1, Bus::NULL, 0, 0);
        cyc(Bus::IDLE, 0, Bus::NULL, 0, 1);
        chk("tmo_cleared", timeout, 1'b0);
        cyc(Bus::IDLE, 0, Bus::NULL, 0, 1);
        cyc(Bus::READ, 1, Bus::NULL, 0, 0);
        chk("abort_open", draining, 1'b0);
        chk("abort_cnt", dut.u_cnt.count_q, 2'd2);
        cyc(Bus::READ, 1, Bus::NULL, 0, 0);
        chk("abort_new_cmd", dut.u_cnt.count_q, 2'd3);
        repeat (3) cyc(Bus::IDLE, 0, Bus::DVA, 1, 0);

        // Saturation, then asynchronous reset mid-DRAIN.
        repeat (4) cyc(Bus::READ, 1, Bus::NULL, 0, 0);
        chk("sat_cnt", dut.u_cnt.count_q, 2'd3);
        chk("sat_ovf", overflow, 1'b1);
        cyc(Bus::IDLE, 0, Bus::NULL, 0, 1);
        cyc(Bus::IDLE, 0, Bus::NULL, 0, 1);
        reset = 1'b1;
        #1;
        model_reset();
        check_regs();
        chk("rst_ovf", overflow, 1'b0);
        drive(Bus::READ, 1, Bus::NULL, 0, 0);
        reset = 1'b0;
        tick();

        // Random traffic with alternating response-rich and response-starved epochs.
        creq = 1'b0;
        for (int i = 0; i < 800; i++) begin
            rpct = ((i / 100) % 2 == 1) ? 40 : 6;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rc = Bus::IDLE;
                4, 5, 6, 7: rc = Bus::READ;
                default:    rc = Bus::WRITE;
            endcase
            if ($urandom_range(0, 99) < rpct)
                rr = ($urandom_range(0, 3) == 0) ? Bus::ERR : Bus::DVA;
            else
                rr = Bus::NULL;
            if ($urandom_range(0, 9) == 0) creq = ~creq;
            cyc(rc, 1'($urandom_range(0, 1)), rr, ($urandom_range(0, 3) != 0), creq);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
